// File: rtl/fft_control_param.sv
// Address and sequence controller for an in-place radix-4 FFT over four
// memory banks with a ping-pong memory set (A/B). Transform size is
// 2^N_LOG2 points; an odd N_LOG2 finishes with a radix-2 stage.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | ready, waiting for iSTART; controller does not own memories
// ST_RUN   | issuing one butterfly read per cycle, b = 0..NB-1
// ST_FLUSH | LAT-cycle drain so the stage's writes land before next reads
module fft_control_param #(
   parameter int N_LOG2 = 11,
   parameter int LAT    = 3,
   parameter int ST_W   = 3
) (
   input  logic              iCLK,
   input  logic              iRESET,
   input  logic              iSTART,
   input  logic              iABORT,
   output logic [1:0]        oBANK_RD_ROT,
   output logic [1:0]        oBANK_WR_ROT,
   output logic [N_LOG2-3:0] oADDR_RD_0,
   output logic [N_LOG2-3:0] oADDR_RD_1,
   output logic [N_LOG2-3:0] oADDR_RD_2,
   output logic [N_LOG2-3:0] oADDR_RD_3,
   output logic [N_LOG2-3:0] oADDR_WR,
   output logic [N_LOG2-3:0] oADDR_COEF,
   output logic              oRD_VAL,
   output logic              oWE_A,
   output logic              oWE_B,
   output logic              oSOURCE_DATA,
   output logic              oSOURCE_CONT,
   output logic              oBUT_TYPE,
   output logic [ST_W-1:0]   oSTAGE,
   output logic              oRDY,
   output logic              oDONE
);

   localparam int A_W   = N_LOG2 - 2;
   localparam int S     = (N_LOG2 + 1) / 2;
   localparam int ND    = (A_W + 1) / 2;
   localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

   localparam logic [A_W-1:0]   LAST_B     = '1;
   localparam logic [ST_W-1:0]  LAST_S     = ST_W'(S - 1);
   localparam logic             ODD_N      = ((N_LOG2 % 2) == 1);
   localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(LAT - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_FLUSH
   } state_t;

   state_t           state_q, state_nxt;
   logic [A_W-1:0]   b_q, b_nxt;
   logic [ST_W-1:0]  s_q, s_nxt;
   logic [CNT_W-1:0] cnt_q, cnt_nxt;
   logic             done_nxt;
   logic             run_nxt;
   logic [1:0]       rot_nxt;

   logic             dl_v   [LAT];
   logic [A_W-1:0]   dl_b   [LAT];
   logic [1:0]       dl_rot [LAT];
   logic             dl_s0  [LAT];

   // Bank rotation: base-4 digit sum of the butterfly index, modulo 4.
   function automatic logic [1:0] digit_sum(input logic [A_W-1:0] v);
      logic [2*ND-1:0] ext;
      logic [1:0]      acc;
      ext = (2*ND)'(v);
      acc = 2'd0;
      for (int i = 0; i < ND; i++) begin
         acc = acc + ext[2*i +: 2];
      end
      return acc;
   endfunction

   // Next-state, butterfly/stage counters and the flush down-counter.
   always_comb begin
      state_nxt = state_q;
      b_nxt     = b_q;
      s_nxt     = s_q;
      cnt_nxt   = cnt_q;
      done_nxt  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (iSTART) begin
               state_nxt = ST_RUN;
               b_nxt     = '0;
               s_nxt     = '0;
            end
         end
         ST_RUN: begin
            if (b_q == LAST_B) begin
               state_nxt = ST_FLUSH;
               cnt_nxt   = FLUSH_LOAD;
            end else begin
               b_nxt = b_q + 1'b1;
            end
         end
         ST_FLUSH: begin
            if (cnt_q == '0) begin
               if (s_q == LAST_S) begin
                  state_nxt = ST_IDLE;
                  done_nxt  = 1'b1;
               end else begin
                  state_nxt = ST_RUN;
                  s_nxt     = s_q + 1'b1;
                  b_nxt     = '0;
               end
            end else begin
               cnt_nxt = cnt_q - 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
      // Abort wins over everything, including a start in IDLE.
      if (iABORT) begin
         state_nxt = ST_IDLE;
         done_nxt  = 1'b0;
      end
      run_nxt = (state_nxt == ST_RUN);
      rot_nxt = digit_sum(b_nxt);
   end

   // FSM state and counter registers.
   always_ff @(posedge iCLK) begin
      if (iRESET) begin
         state_q <= ST_IDLE;
         b_q     <= '0;
         s_q     <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_nxt;
         b_q     <= b_nxt;
         s_q     <= s_nxt;
         cnt_q   <= cnt_nxt;
      end
   end

   // Read-side and status outputs, registered from the next-state values
   // so they line up with the cycle the FSM is in.
   always_ff @(posedge iCLK) begin
      if (iRESET) begin
         oRD_VAL      <= 1'b0;
         oRDY         <= 1'b1;
         oSOURCE_CONT <= 1'b0;
         oDONE        <= 1'b0;
         oBUT_TYPE    <= 1'b0;
         oADDR_RD_0   <= '0;
         oADDR_RD_1   <= '0;
         oADDR_RD_2   <= '0;
         oADDR_RD_3   <= '0;
         oADDR_COEF   <= '0;
         oBANK_RD_ROT <= '0;
         oSOURCE_DATA <= 1'b0;
         oSTAGE       <= '0;
      end else begin
         oRD_VAL      <= run_nxt;
         oRDY         <= (state_nxt == ST_IDLE);
         oSOURCE_CONT <= (state_nxt != ST_IDLE);
         oDONE        <= done_nxt;
         oBUT_TYPE    <= run_nxt & (s_nxt == LAST_S) & ODD_N;
         if (run_nxt) begin
            oADDR_RD_0   <= b_nxt;
            oADDR_RD_1   <= b_nxt;
            oADDR_RD_2   <= b_nxt;
            oADDR_RD_3   <= b_nxt;
            oADDR_COEF   <= b_nxt << {s_nxt, 1'b0};
            oBANK_RD_ROT <= rot_nxt;
            oSOURCE_DATA <= s_nxt[0];
            oSTAGE       <= s_nxt;
         end
      end
   end

   // Write delay line; entry 0 mirrors the read registers, so the last
   // entry feeding the write registers yields exactly LAT cycles of delay.
   always_ff @(posedge iCLK) begin
      if (iRESET || iABORT) begin
         for (int k = 0; k < LAT; k++) begin
            dl_v[k]   <= 1'b0;
            dl_b[k]   <= '0;
            dl_rot[k] <= '0;
            dl_s0[k]  <= 1'b0;
         end
      end else begin
         dl_v[0]   <= run_nxt;
         dl_b[0]   <= b_nxt;
         dl_rot[0] <= rot_nxt;
         dl_s0[0]  <= s_nxt[0];
         for (int k = 1; k < LAT; k++) begin
            dl_v[k]   <= dl_v[k-1];
            dl_b[k]   <= dl_b[k-1];
            dl_rot[k] <= dl_rot[k-1];
            dl_s0[k]  <= dl_s0[k-1];
         end
      end
   end

   // Write outputs; the write always targets the set not being read.
   always_ff @(posedge iCLK) begin
      if (iRESET) begin
         oWE_A        <= 1'b0;
         oWE_B        <= 1'b0;
         oADDR_WR     <= '0;
         oBANK_WR_ROT <= '0;
      end else if (iABORT) begin
         oWE_A <= 1'b0;
         oWE_B <= 1'b0;
      end else begin
         oWE_A <= dl_v[LAT-1] & dl_s0[LAT-1];
         oWE_B <= dl_v[LAT-1] & ~dl_s0[LAT-1];
         if (dl_v[LAT-1]) begin
            oADDR_WR     <= dl_b[LAT-1];
            oBANK_WR_ROT <= dl_rot[LAT-1];
         end
      end
   end

endmodule

// File: tb/tb_fft_control_param.sv
// Scoreboard bench for fft_control_param: three instances (N_LOG2/LAT =
// 4/2, 6/1, 5/3). Stimulus pushes expected reads, writes and done pulses
// into per-instance queues; a negedge monitor pops and compares them, and
// also evaluates directed single-cycle expectations.
module tb_fft_control_param;

   typedef struct {
      int cyc; int addr; int rot; int coef; int src; int bt; int stg;
   } rd_t;
   typedef struct {
      int cyc; int addr; int rot; int set_b;
   } wr_t;
   typedef struct {
      int cyc; int inst; int sel; int val; string name;
   } dir_t;

   localparam int SEL_RDY  = 0;
   localparam int SEL_DONE = 1;
   localparam int SEL_ROT  = 2;
   localparam int SEL_COEF = 3;
   localparam int SEL_BT   = 4;
   localparam int SEL_SRCD = 5;
   localparam int SEL_RDV  = 6;
   localparam int SEL_SRCC = 7;
   localparam int SEL_WE   = 8;
   localparam int SEL_RST  = 9;

   logic       clk;
   logic       rst;
   logic [2:0] start;
   logic [2:0] abort;
   int         cyc = 0;

   int m_rd_val[3], m_a0[3], m_a1[3], m_a2[3], m_a3[3], m_aw[3], m_coef[3];
   int m_rot_rd[3], m_rot_wr[3], m_we_a[3], m_we_b[3], m_src_d[3];
   int m_src_c[3], m_bt[3], m_stage[3], m_rdy[3], m_done[3];

   rd_t  rd_q[3][$];
   wr_t  wr_q[3][$];
   int   done_q[3][$];
   dir_t dir_q[$];

   bit finishing = 1'b0;
   int checks    = 0;
   int failures  = 0;

   genvar g;
   generate
      for (g = 0; g < 3; g++) begin : g_dut
         localparam int NL = (g == 0) ? 4 : (g == 1) ? 6 : 5;
         localparam int LT = (g == 0) ? 2 : (g == 1) ? 1 : 3;
         localparam int AW = NL - 2;
         logic [AW-1:0] a0, a1, a2, a3, aw, ac;
         logic [1:0]    rr, rw;
         logic [2:0]    stg;
         logic          rv, wa, wb, sd, sc, bt, rdy, dn;
         fft_control_param #(.N_LOG2(NL), .LAT(LT), .ST_W(3)) u_dut (
            .iCLK(clk), .iRESET(rst), .iSTART(start[g]), .iABORT(abort[g]),
            .oBANK_RD_ROT(rr), .oBANK_WR_ROT(rw),
            .oADDR_RD_0(a0), .oADDR_RD_1(a1), .oADDR_RD_2(a2), .oADDR_RD_3(a3),
            .oADDR_WR(aw), .oADDR_COEF(ac), .oRD_VAL(rv),
            .oWE_A(wa), .oWE_B(wb), .oSOURCE_DATA(sd), .oSOURCE_CONT(sc),
            .oBUT_TYPE(bt), .oSTAGE(stg), .oRDY(rdy), .oDONE(dn)
         );
         assign m_rd_val[g] = int'(rv);
         assign m_a0[g]     = int'(a0);
         assign m_a1[g]     = int'(a1);
         assign m_a2[g]     = int'(a2);
         assign m_a3[g]     = int'(a3);
         assign m_aw[g]     = int'(aw);
         assign m_coef[g]   = int'(ac);
         assign m_rot_rd[g] = int'(rr);
         assign m_rot_wr[g] = int'(rw);
         assign m_we_a[g]   = int'(wa);
         assign m_we_b[g]   = int'(wb);
         assign m_src_d[g]  = int'(sd);
         assign m_src_c[g]  = int'(sc);
         assign m_bt[g]     = int'(bt);
         assign m_stage[g]  = int'(stg);
         assign m_rdy[g]    = int'(rdy);
         assign m_done[g]   = int'(dn);
      end
   endgenerate

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle counter: cycle k of a scenario is when cyc == start_cycle + k.
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int nl_of(input int i);
      case (i)
         0:       return 4;
         1:       return 6;
         default: return 5;
      endcase
   endfunction

   function automatic int lt_of(input int i);
      case (i)
         0:       return 2;
         1:       return 1;
         default: return 3;
      endcase
   endfunction

   function automatic int model_rot(input int b);
      int sum;
      int v;
      sum = 0;
      v   = b;
      while (v > 0) begin
         sum = sum + (v % 4);
         v   = v / 4;
      end
      return sum % 4;
   endfunction

   // Expected transactions of a transform started (iSTART sampled) at
   // cycle c0; anything later than 'limit' is cut off (abort/reset).
   function automatic void push_run(input int i, input int c0, input int limit);
      int  nl;
      int  lt;
      int  nb;
      int  ns;
      rd_t r;
      wr_t w;
      nl = nl_of(i);
      lt = lt_of(i);
      nb = 1 << (nl - 2);
      ns = (nl + 1) / 2;
      for (int s = 0; s < ns; s++) begin
         for (int b = 0; b < nb; b++) begin
            r.cyc  = c0 + 1 + s * (nb + lt) + b;
            r.addr = b;
            r.rot  = model_rot(b);
            r.coef = (b << (2 * s)) % nb;
            r.src  = s % 2;
            r.bt   = (s == ns - 1 && (nl % 2) == 1) ? 1 : 0;
            r.stg  = s;
            if (r.cyc <= limit) rd_q[i].push_back(r);
            w.cyc   = r.cyc + lt;
            w.addr  = b;
            w.rot   = r.rot;
            w.set_b = (s % 2 == 0) ? 1 : 0;
            if (w.cyc <= limit) wr_q[i].push_back(w);
         end
      end
      if (c0 + ns * (nb + lt) + 1 <= limit) done_q[i].push_back(c0 + ns * (nb + lt) + 1);
   endfunction

   function automatic void expect_at(input int c, input int i, input int sel,
                                     input int val, input string name);
      dir_t d;
      d.cyc  = c;
      d.inst = i;
      d.sel  = sel;
      d.val  = val;
      d.name = name;
      dir_q.push_back(d);
   endfunction

   function automatic int get_field(input int i, input int sel);
      case (sel)
         SEL_RDY:  return m_rdy[i];
         SEL_DONE: return m_done[i];
         SEL_ROT:  return m_rot_rd[i];
         SEL_COEF: return m_coef[i];
         SEL_BT:   return m_bt[i];
         SEL_SRCD: return m_src_d[i];
         SEL_RDV:  return m_rd_val[i];
         SEL_SRCC: return m_src_c[i];
         SEL_WE:   return m_we_a[i] + 2 * m_we_b[i];
         default:  return (m_rdy[i] == 1 && m_rd_val[i] == 0 && m_a0[i] == 0 &&
                           m_a1[i] == 0 && m_a2[i] == 0 && m_a3[i] == 0 &&
                           m_aw[i] == 0 && m_coef[i] == 0 && m_rot_rd[i] == 0 &&
                           m_rot_wr[i] == 0 && m_we_a[i] == 0 && m_we_b[i] == 0 &&
                           m_src_d[i] == 0 && m_src_c[i] == 0 && m_bt[i] == 0 &&
                           m_stage[i] == 0 && m_done[i] == 0) ? 1 : 0;
      endcase
   endfunction

   // Monitor: all comparisons happen here, on the falling edge.
   always @(negedge clk) begin : monitor
      rd_t r;
      wr_t w;
      int  d;
      for (int i = 0; i < 3; i++) begin
         if (m_rd_val[i] != 0) begin
            checks++;
            if (rd_q[i].size() == 0) begin
               failures++;
               $display("FAIL rd_extra inst%0d cyc=%0d: got read addr=%0d, required no read",
                        i, cyc, m_a0[i]);
            end else begin
               r = rd_q[i].pop_front();
               if (cyc != r.cyc || m_a0[i] != r.addr || m_a1[i] != r.addr ||
                   m_a2[i] != r.addr || m_a3[i] != r.addr || m_rot_rd[i] != r.rot ||
                   m_coef[i] != r.coef || m_src_d[i] != r.src || m_bt[i] != r.bt ||
                   m_stage[i] != r.stg) begin
                  failures++;
                  $display("FAIL rd inst%0d: got cyc=%0d addr=%0d,%0d,%0d,%0d rot=%0d coef=%0d src=%0d bt=%0d stg=%0d; required cyc=%0d addr=%0d rot=%0d coef=%0d src=%0d bt=%0d stg=%0d",
                           i, cyc, m_a0[i], m_a1[i], m_a2[i], m_a3[i], m_rot_rd[i],
                           m_coef[i], m_src_d[i], m_bt[i], m_stage[i],
                           r.cyc, r.addr, r.rot, r.coef, r.src, r.bt, r.stg);
               end
            end
         end else begin
            checks++;
            if (m_bt[i] != 0) begin
               failures++;
               $display("FAIL bt_idle inst%0d cyc=%0d: got oBUT_TYPE=%0d, required 0",
                        i, cyc, m_bt[i]);
            end
         end
         if (m_we_a[i] != 0 || m_we_b[i] != 0) begin
            checks++;
            if (wr_q[i].size() == 0) begin
               failures++;
               $display("FAIL wr_extra inst%0d cyc=%0d: got we_a=%0d we_b=%0d addr=%0d, required no write",
                        i, cyc, m_we_a[i], m_we_b[i], m_aw[i]);
            end else begin
               w = wr_q[i].pop_front();
               if (cyc != w.cyc || m_aw[i] != w.addr || m_rot_wr[i] != w.rot ||
                   m_we_b[i] != w.set_b || m_we_a[i] != 1 - w.set_b) begin
                  failures++;
                  $display("FAIL wr inst%0d: got cyc=%0d addr=%0d rot=%0d we_a=%0d we_b=%0d; required cyc=%0d addr=%0d rot=%0d we_a=%0d we_b=%0d",
                           i, cyc, m_aw[i], m_rot_wr[i], m_we_a[i], m_we_b[i],
                           w.cyc, w.addr, w.rot, 1 - w.set_b, w.set_b);
               end
            end
         end
         if (m_done[i] != 0) begin
            checks++;
            if (done_q[i].size() == 0) begin
               failures++;
               $display("FAIL done_extra inst%0d: got oDONE=1 at cyc=%0d, required no done", i, cyc);
            end else begin
               d = done_q[i].pop_front();
               if (cyc != d) begin
                  failures++;
                  $display("FAIL done inst%0d: got oDONE at cyc=%0d, required cyc=%0d", i, cyc, d);
               end
            end
         end
      end
      for (int k = dir_q.size() - 1; k >= 0; k--) begin
         if (dir_q[k].cyc == cyc) begin
            checks++;
            d = get_field(dir_q[k].inst, dir_q[k].sel);
            if (d != dir_q[k].val) begin
               failures++;
               $display("FAIL %s inst%0d cyc=%0d: got %0d, required %0d",
                        dir_q[k].name, dir_q[k].inst, cyc, d, dir_q[k].val);
            end
            dir_q.delete(k);
         end
      end
      if (finishing) begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (rd_q[i].size() != 0 || wr_q[i].size() != 0 || done_q[i].size() != 0) begin
               failures++;
               $display("FAIL missing inst%0d: got %0d/%0d/%0d reads/writes/dones outstanding, required 0/0/0",
                        i, rd_q[i].size(), wr_q[i].size(), done_q[i].size());
            end
         end
         checks++;
         if (dir_q.size() != 0) begin
            failures++;
            $display("FAIL dir_missed: got %0d directed expectations unevaluated, required 0", dir_q.size());
         end
         $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
         $finish;
      end
   end

   task automatic wait_cyc(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   initial begin : stimulus
      int c;
      rst   = 1'b1;
      start = 3'b000;
      abort = 3'b000;
      for (int i = 0; i < 3; i++) expect_at(3, i, SEL_RST, 1, "reset_values");
      wait_cyc(4);
      rst = 1'b0;
      wait_cyc(6);

      // All three configurations started together.
      c = cyc;
      for (int i = 0; i < 3; i++) push_run(i, c, 1 << 30);
      expect_at(c + 1,  0, SEL_RDY,  0, "n4_rdy_c1");
      expect_at(c + 1,  0, SEL_SRCC, 1, "n4_srccont_c1");
      expect_at(c + 5,  0, SEL_RDV,  0, "n4_flush_rdval");
      expect_at(c + 7,  1, SEL_ROT,  3, "n6_rot_s0_b6");
      expect_at(c + 7,  1, SEL_COEF, 6, "n6_coef_s0_b6");
      expect_at(c + 12, 0, SEL_RDY,  0, "n4_rdy_c12");
      expect_at(c + 12, 0, SEL_SRCD, 1, "n4_srcdata_s1");
      expect_at(c + 12, 2, SEL_BT,   0, "n5_bt_s1");
      expect_at(c + 13, 0, SEL_RDY,  1, "n4_rdy_c13");
      expect_at(c + 13, 0, SEL_DONE, 1, "n4_done_c13");
      expect_at(c + 13, 0, SEL_SRCC, 0, "n4_srccont_c13");
      expect_at(c + 14, 0, SEL_DONE, 0, "n4_done_pulse");
      expect_at(c + 23, 2, SEL_BT,   1, "n5_bt_s2");
      expect_at(c + 24, 1, SEL_COEF, 8, "n6_coef_s1_b6");
      expect_at(c + 34, 2, SEL_DONE, 1, "n5_done_c34");
      start = 3'b111;
      wait_cyc(c + 1);
      start = 3'b000;
      wait_cyc(c + 60);

      // Start pulses during a run are ignored.
      c = cyc;
      push_run(0, c, 1 << 30);
      expect_at(c + 12, 0, SEL_RDY, 0, "ign_rdy_c12");
      expect_at(c + 13, 0, SEL_RDY, 1, "ign_rdy_c13");
      start[0] = 1'b1;
      wait_cyc(c + 1);  start[0] = 1'b0;
      wait_cyc(c + 3);  start[0] = 1'b1;
      wait_cyc(c + 4);  start[0] = 1'b0;
      wait_cyc(c + 8);  start[0] = 1'b1;
      wait_cyc(c + 9);  start[0] = 1'b0;
      wait_cyc(c + 20);

      // Start held high: a second transform begins right after completion.
      c = cyc;
      push_run(0, c, 1 << 30);
      push_run(0, c + 13, 1 << 30);
      expect_at(c + 14, 0, SEL_RDY, 0, "held_restart");
      expect_at(c + 27, 0, SEL_DONE, 0, "held_done_pulse");
      start[0] = 1'b1;
      wait_cyc(c + 14);
      start[0] = 1'b0;
      wait_cyc(c + 35);

      // Abort in the first flush: no pending write after cycle 5, no done.
      c = cyc;
      push_run(0, c, c + 5);
      expect_at(c + 6,  0, SEL_RDY,  1, "abort_rdy");
      expect_at(c + 6,  0, SEL_RDV,  0, "abort_rdval");
      expect_at(c + 6,  0, SEL_SRCC, 0, "abort_srccont");
      expect_at(c + 6,  0, SEL_WE,   0, "abort_we");
      expect_at(c + 20, 0, SEL_RDY,  1, "abort_stays_idle");
      start[0] = 1'b1;
      wait_cyc(c + 1);  start[0] = 1'b0;
      wait_cyc(c + 5);  abort[0] = 1'b1;
      wait_cyc(c + 6);  abort[0] = 1'b0;
      wait_cyc(c + 25);

      // Reset in the middle of a run.
      c = cyc;
      push_run(0, c, c + 4);
      expect_at(c + 4, 0, SEL_RDV, 1, "pre_reset_rdval");
      expect_at(c + 5, 0, SEL_RST, 1, "mid_reset_values");
      start[0] = 1'b1;
      wait_cyc(c + 1);  start[0] = 1'b0;
      wait_cyc(c + 4);  rst = 1'b1;
      wait_cyc(c + 5);  rst = 1'b0;
      wait_cyc(c + 20);

      finishing = 1'b1;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got no summary by time limit, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/fft_control_param.md
Name: fft_control_param

Overview:
- Parametrised successor of fft_control: the address/sequence controller for the in-place radix-4 FFT over 4 memory banks, with a ping-pong memory set A/B.
- Generalised in transform size (2^N_LOG2 points) and butterfly pipeline latency.
- When N_LOG2 is odd, the final stage is radix-2.
- Adds abort, read-valid/stage status and a completion pulse. Drives bank rotation, read/write/coef addresses, write enables, source selects and butterfly type toward the butterfly datapath and the bank memories.

Parameters:
- N_LOG2, 11, log2 of FFT points (min 4). Derived: A_W = N_LOG2-2 (bank address width), NB = 2^A_W (butterflies per stage), S = ceil(N_LOG2/2) (stages).
- LAT, 3, cycles from read address issue to matching write (butterfly + memory latency), min 1.
- ST_W, 3, width of stage index output (must satisfy 2^ST_W >= S).

Ports:
- iCLK  in  1  clock
- iRESET  in  1  synchronous reset, active-high
- iSTART  in  1  start request, sampled in IDLE only
- iABORT  in  1  synchronous abort
- oBANK_RD_ROT  out  2  read bank rotation
- oBANK_WR_ROT  out  2  write bank rotation
- oADDR_RD_0..oADDR_RD_3  out  A_W each  per-bank read address
- oADDR_WR  out  A_W  write address (common to all banks)
- oADDR_COEF  out  A_W  twiddle ROM address
- oRD_VAL  out  1  read addresses valid this cycle
- oWE_A  out  1  write enable, memory set A
- oWE_B  out  1  write enable, memory set B
- oSOURCE_DATA  out  1  read set select: 0=A, 1=B
- oSOURCE_CONT  out  1  1 = controller owns memories
- oBUT_TYPE  out  1  0 = radix-4, 1 = radix-2
- oSTAGE  out  ST_W  current read stage
- oRDY  out  1  idle/ready
- oDONE  out  1  one-cycle completion pulse

Behaviour:
- All outputs are registered.
- Reset values:
  - oRDY = 1.
  - All other outputs = 0.
  - State = IDLE.
  - Internal counters and the write delay line are cleared.
- States: IDLE, RUN, FLUSH.
- IDLE -> RUN:
  - Triggered by iSTART=1 at cycle 0.
  - At cycle 1: oRDY = 0, oSOURCE_CONT = 1, stage s = 0, butterfly b = 0, oRD_VAL = 1.
- RUN:
  - One butterfly per cycle; b increments 0..NB-1.
  - After b = NB-1, go to FLUSH with oRD_VAL = 0.
- FLUSH:
  - Lasts LAT cycles.
  - If s < S-1: s++, b = 0, back to RUN.
  - Otherwise: IDLE, oRDY = 1, oDONE = 1 for one cycle, oSOURCE_CONT = 0.
- Timing:
  - Stage s reads occupy cycles Ts..Ts+NB-1, where Ts = 1 + s*(NB+LAT).
  - Last write is at cycle S*(NB+LAT).
  - oDONE and oRDY rise at cycle S*(NB+LAT)+1.
- Read addressing, while oRD_VAL = 1:
  - oADDR_RD_k = b for k = 0..3.
  - oBANK_RD_ROT = (sum of the 2-bit digits of b, top digit zero-extended if A_W is odd) mod 4.
  - oADDR_COEF = (b << 2s) truncated to A_W bits.
  - oSOURCE_DATA = s[0].
  - oBUT_TYPE = 1 iff s = S-1 and N_LOG2 is odd.
  - oSTAGE = s.
- Write path:
  - A LAT-deep delay line carries {valid, b, rotation, s[0]}.
  - oADDR_WR, oBANK_WR_ROT and the write strobe equal the read-side values delayed by exactly LAT cycles.
  - The write goes to the opposite set: oWE_B = valid & ~s[0], oWE_A = valid & s[0].
  - Exactly one write per read; oWE_A and oWE_B are never both 1.
- Outside valid cycles, address outputs hold their last value.
- iSTART:
  - Ignored in RUN and FLUSH.
  - iSTART held high in IDLE after completion starts a new transform on the next cycle.
- iABORT (any state, priority over iSTART):
  - Next cycle: IDLE, oRDY = 1, oRD_VAL = 0, oWE_A = 0, oWE_B = 0.
  - The delay line is cleared, so no pending writes are emitted.
  - oDONE stays 0; oSOURCE_CONT = 0.
- iRESET mid-operation: identical to abort, plus all outputs return to their reset values.
- Counter wrap: b wraps only via the stage transition; s never exceeds S-1.

Test Plan:
- N_LOG2=4, LAT=2, iSTART pulse at cycle 0:
  - RUN cycles 1-4 and 7-10; oRD_VAL high for 8 cycles.
  - oRDY=0 in cycles 1-12; oDONE=1 and oRDY=1 at cycle 13.
  - oSOURCE_DATA = 0 then 1.
- Same configuration, write path:
  - oWE_B=1 in cycles 3-6 with oADDR_WR 0,1,2,3.
  - oWE_A=1 in cycles 9-12.
  - oBANK_WR_ROT equals oBANK_RD_ROT delayed 2 cycles (b=3 -> rot 3).
- N_LOG2=6, LAT=1: at s=0, b=6, oBANK_RD_ROT=3 and oADDR_COEF=6; at s=1, b=6, oADDR_COEF=8; oBUT_TYPE=0 throughout.
- N_LOG2=5, LAT=3:
  - S=3; oBUT_TYPE=1 only during stage 2 reads.
  - oDONE at cycle 3*(8+3)+1 = 34.
- iABORT at cycle 5 of the N_LOG2=4 run: cycle 6 IDLE, oRDY=1, no oWE_A or oWE_B thereafter, oDONE never asserted.
- iSTART pulsed at cycles 3 and 8 during a run: ignored, with timing identical to the first scenario. Then iRESET at cycle 4 of a fresh run: all outputs return to reset values at cycle 5.
